// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and segment encodings for the 7-segment drivers.
//   bcd_t      - one BCD digit
//   seg_t      - segment vector, a at index 0 (MSB) through g at index 6 (LSB), active-low
//   bcd_to_seg - decodes a BCD digit to its segment pattern; codes above 9 decode as zero
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_ZERO  = 7'b0000001;
    localparam seg_t SEG_ONE   = 7'b1001111;
    localparam seg_t SEG_TWO   = 7'b0010010;
    localparam seg_t SEG_THREE = 7'b0000110;
    localparam seg_t SEG_FOUR  = 7'b1001100;
    localparam seg_t SEG_FIVE  = 7'b0100100;
    localparam seg_t SEG_SIX   = 7'b0100000;
    localparam seg_t SEG_SEVEN = 7'b0001111;
    localparam seg_t SEG_EIGHT = 7'b0000000;
    localparam seg_t SEG_NINE  = 7'b0000100;
    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t bcd_to_seg(input bcd_t d);
        seg_t s;
        case (d)
            4'd0:    s = SEG_ZERO;
            4'd1:    s = SEG_ONE;
            4'd2:    s = SEG_TWO;
            4'd3:    s = SEG_THREE;
            4'd4:    s = SEG_FOUR;
            4'd5:    s = SEG_FIVE;
            4'd6:    s = SEG_SIX;
            4'd7:    s = SEG_SEVEN;
            4'd8:    s = SEG_EIGHT;
            4'd9:    s = SEG_NINE;
            default: s = SEG_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_blink.sv
// seg7_blink: millisecond blink scheduler.
//   clk, rst      - clock, synchronous active-high reset
//   tick_1ms      - one-cycle 1 ms enable
//   blink_en      - enables blinking; counter held at 0 while low
//   blink_period  - period in ms (0 or 1 disables blinking)
//   blink_on      - visible ms per period
//   blank_phase   - high while the display should be blank
module seg7_blink #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1ms,
    input  logic             blink_en,
    input  logic [CNT_W-1:0] blink_period,
    input  logic [CNT_W-1:0] blink_on,
    output logic             blank_phase
);

    logic [CNT_W-1:0] r_bcnt;
    logic             w_active;

    assign w_active = blink_en && (blink_period > CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt <= '0;
        end else if (!w_active) begin
            r_bcnt <= '0;
        end else if (tick_1ms) begin
            // ">=" so a period shortened below the current count wraps on the next tick
            if (r_bcnt >= blink_period - CNT_W'(1))
                r_bcnt <= '0;
            else
                r_bcnt <= r_bcnt + CNT_W'(1);
        end
    end

    assign blank_phase = w_active && (r_bcnt >= blink_on);

endmodule

// File: rtl/seg7_autorange.sv
// seg7_autorange: auto-ranging 7-segment driver.
//   clk, rst      - clock, synchronous active-high reset
//   bcd           - packed BCD input, digit 0 = ones
//   bcd_valid     - strobe latching bcd
//   tick_1ms      - 1 ms enable for the blink schedule
//   blink_en, blink_period, blink_on - blink control
//   hex           - active-low segments, digit k at [7k+6:7k], a..g MSB->LSB
//   range_led     - one-hot selected window shift
//   bcd_err       - sticky flag for a latched digit above 9
module seg7_autorange
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned NUM_BCD    = 6,
    parameter int unsigned LZ_BLANK   = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_BCD*4-1:0]             bcd,
    input  logic                             bcd_valid,
    input  logic                             tick_1ms,
    input  logic                             blink_en,
    input  logic [CNT_W-1:0]                 blink_period,
    input  logic [CNT_W-1:0]                 blink_on,
    output logic [NUM_DIGITS*7-1:0]          hex,
    output logic [NUM_BCD-NUM_DIGITS:0]      range_led,
    output logic                             bcd_err
);

    localparam int unsigned NUM_SHIFT = NUM_BCD - NUM_DIGITS + 1;
    localparam int unsigned IDX_W     = (NUM_BCD > 1) ? $clog2(NUM_BCD) : 1;

    logic [NUM_BCD*4-1:0]    r_val;
    logic [IDX_W-1:0]        r_msd;
    logic [IDX_W-1:0]        r_shift;
    logic                    r_seen;
    logic                    r_err;
    logic [NUM_DIGITS*7-1:0] r_hex;
    logic [NUM_SHIFT-1:0]    r_range;

    logic [IDX_W-1:0]        w_msd;
    logic [IDX_W-1:0]        w_shift;
    logic                    w_bad;
    logic [NUM_DIGITS*7-1:0] w_hex;
    logic [NUM_SHIFT-1:0]    w_range;
    logic                    w_blank;

    function automatic bcd_t digit_at(input logic [NUM_BCD*4-1:0] v, input int unsigned p);
        return v[4*p +: 4];
    endfunction

    seg7_blink #(.CNT_W(CNT_W)) u_blink (
        .clk          (clk),
        .rst          (rst),
        .tick_1ms     (tick_1ms),
        .blink_en     (blink_en),
        .blink_period (blink_period),
        .blink_on     (blink_on),
        .blank_phase  (w_blank)
    );

    // MSD scan and window shift on the incoming value, registered alongside it
    always_comb begin
        w_msd   = '0;
        w_bad   = 1'b0;
        w_shift = '0;
        for (int unsigned i = 0; i < NUM_BCD; i++) begin
            if (digit_at(bcd, i) != 4'd0) w_msd = IDX_W'(i);
            if (digit_at(bcd, i) > 4'd9)  w_bad = 1'b1;
        end
        if (w_msd > IDX_W'(NUM_DIGITS - 1))
            w_shift = w_msd - IDX_W'(NUM_DIGITS - 1);
        if (w_shift > IDX_W'(NUM_BCD - NUM_DIGITS))
            w_shift = IDX_W'(NUM_BCD - NUM_DIGITS);
    end

    always_comb begin
        w_hex = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (LZ_BLANK != 0 && k > 0 && (32'(r_shift) + k > 32'(r_msd)))
                w_hex[7*k +: 7] = SEG_BLANK;
            else
                w_hex[7*k +: 7] = bcd_to_seg(digit_at(r_val, 32'(r_shift) + k));
        end
        w_range = NUM_SHIFT'(1) << r_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val   <= '0;
            r_msd   <= '0;
            r_shift <= '0;
            r_seen  <= 1'b0;
            r_err   <= 1'b0;
            r_hex   <= '1;
            r_range <= '0;
        end else begin
            if (bcd_valid) begin
                r_val   <= bcd;
                r_msd   <= w_msd;
                r_shift <= w_shift;
                r_seen  <= 1'b1;
                if (w_bad) r_err <= 1'b1;
            end
            if (r_seen && !w_blank)
                r_hex <= w_hex;
            else
                r_hex <= '1;
            if (r_seen)
                r_range <= w_range;
            else
                r_range <= '0;
        end
    end

    assign hex       = r_hex;
    assign range_led = r_range;
    assign bcd_err   = r_err;

endmodule

// File: tb/tb_seg7_autorange.sv
module tb_seg7_autorange;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [27:0] ALLB = 28'hFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] bcd;
    logic        bcd_valid;
    logic        tick;
    logic        blink_en;
    logic [15:0] per;
    logic [15:0] on_ms;
    logic [27:0] hex, hex_lz;
    logic [2:0]  rng, rng_lz;
    logic        err, err_lz;

    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    typedef struct {
        int unsigned at;
        string       name;
        logic [27:0] h;
        logic [27:0] hl;
        logic [2:0]  r;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;

    logic [27:0] cur_h, cur_hl;
    logic [2:0]  cur_r;
    logic        cur_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_autorange #(.NUM_DIGITS(4), .NUM_BCD(6), .LZ_BLANK(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bcd(bcd), .bcd_valid(bcd_valid), .tick_1ms(tick),
        .blink_en(blink_en), .blink_period(per), .blink_on(on_ms),
        .hex(hex), .range_led(rng), .bcd_err(err)
    );

    seg7_autorange #(.NUM_DIGITS(4), .NUM_BCD(6), .LZ_BLANK(1), .CNT_W(16)) u_dut_lz (
        .clk(clk), .rst(rst), .bcd(bcd), .bcd_valid(bcd_valid), .tick_1ms(tick),
        .blink_en(blink_en), .blink_period(per), .blink_on(on_ms),
        .hex(hex_lz), .range_led(rng_lz), .bcd_err(err_lz)
    );

    task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, expv);
        end
    endtask

    // Monitor: compares every expectation whose output cycle has arrived
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            m_e = exp_q.pop_front();
            if (m_e.at < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: slot %0d missed at cyc %0d", m_e.name, m_e.at, cyc);
            end else begin
                chk({m_e.name, ".hex"},       hex,    m_e.h);
                chk({m_e.name, ".hex_lz"},    hex_lz, m_e.hl);
                chk({m_e.name, ".range"},     {25'd0, rng},    {25'd0, m_e.r});
                chk({m_e.name, ".range_lz"},  {25'd0, rng_lz}, {25'd0, m_e.r});
                chk({m_e.name, ".err"},       {27'd0, err},    {27'd0, m_e.e});
                chk({m_e.name, ".err_lz"},    {27'd0, err_lz}, {27'd0, m_e.e});
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned at, input string nm, input logic [27:0] h,
                        input logic [27:0] hl, input logic [2:0] r, input logic e);
        exp_t x;
        x.at = at; x.name = nm; x.h = h; x.hl = hl; x.r = r; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic [23:0] v, input string nm, input logic [27:0] h,
                        input logic [27:0] hl, input logic [2:0] r, input logic e);
        bcd       = v;
        bcd_valid = 1'b1;
        push(cyc + 2, nm, h, hl, r, e);
        next();
        bcd_valid = 1'b0;
    endtask

    // k = tick count after this tick; schedule is period 10, 6 ms visible
    task automatic do_tick(input int unsigned k, input string nm);
        tick = 1'b1;
        if ((k % 10) >= 6) push(cyc + 2, nm, ALLB, ALLB, cur_r, cur_e);
        else               push(cyc + 2, nm, cur_h, cur_hl, cur_r, cur_e);
        next();
        tick = 1'b0;
        next();
        next();
    endtask

    initial begin
        rst = 1'b1; bcd = '0; bcd_valid = 1'b0; tick = 1'b0;
        blink_en = 1'b0; per = '0; on_ms = '0;
        next();
        next();
        rst = 1'b0;

        // Reset state held while idle
        for (int unsigned i = 1; i <= 10; i++)
            push(cyc + i, "reset_idle", ALLB, ALLB, 3'b000, 1'b0);
        repeat (10) next();

        // Basic window, leading-zero variant in the second instance
        send(24'h000123, "v000123", {S0, S1, S2, S3}, {SB, S1, S2, S3}, 3'b001, 1'b0);
        next();

        // Back-to-back strobes across all ranges and range boundaries
        send(24'h012345, "v012345", {S1, S2, S3, S4}, {S1, S2, S3, S4}, 3'b010, 1'b0);
        send(24'h987654, "v987654", {S9, S8, S7, S6}, {S9, S8, S7, S6}, 3'b100, 1'b0);
        send(24'h000000, "v000000", {S0, S0, S0, S0}, {SB, SB, SB, S0}, 3'b001, 1'b0);
        send(24'h001234, "v001234", {S1, S2, S3, S4}, {S1, S2, S3, S4}, 3'b001, 1'b0);
        send(24'h010000, "v010000", {S1, S0, S0, S0}, {S1, S0, S0, S0}, 3'b010, 1'b0);
        send(24'h100005, "v100005", {S1, S0, S0, S0}, {S1, S0, S0, S0}, 3'b100, 1'b0);
        send(24'h056789, "v056789", {S5, S6, S7, S8}, {S5, S6, S7, S8}, 3'b010, 1'b0);
        next();
        next();

        // Invalid digit decodes as zero and sets the sticky error
        send(24'h00A123, "v00A123", {S0, S1, S2, S3}, {S0, S1, S2, S3}, 3'b001, 1'b1);
        next();
        send(24'h000042, "err_sticky", {S0, S0, S4, S2}, {SB, SB, S4, S2}, 3'b001, 1'b1);
        next();
        cur_h = {S0, S0, S4, S2}; cur_hl = {SB, SB, S4, S2}; cur_r = 3'b001; cur_e = 1'b1;

        // Blinking: period 10, visible 6
        blink_en = 1'b1; per = 16'd10; on_ms = 16'd6;
        push(cyc + 2, "blink_start", cur_h, cur_hl, cur_r, cur_e);
        next();
        next();
        next();
        for (int unsigned k = 1; k <= 20; k++) begin
            do_tick(k, "blink");
            if (k == 7) begin
                send(24'h000123, "valid_in_blank", ALLB, ALLB, 3'b001, 1'b1);
                cur_h = {S0, S1, S2, S3}; cur_hl = {SB, S1, S2, S3};
            end
        end

        // Reset in blank phase, then restart from a visible phase
        for (int unsigned k = 1; k <= 7; k++) do_tick(k, "pre_rst");
        rst = 1'b1;
        push(cyc + 1, "rst_mid", ALLB, ALLB, 3'b000, 1'b0);
        next();
        rst = 1'b0;
        send(24'h000042, "after_rst", {S0, S0, S4, S2}, {SB, SB, S4, S2}, 3'b001, 1'b0);
        next();
        cur_h = {S0, S0, S4, S2}; cur_hl = {SB, SB, S4, S2}; cur_r = 3'b001; cur_e = 1'b0;
        for (int unsigned k = 1; k <= 6; k++) do_tick(k, "post_rst_blink");

        for (int unsigned i = 0; i < 20 && exp_q.size() > 0; i++) next();
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
